// File: rtl/ld_align_unit.sv
// ld_align_unit: sequential load-data unit for the memory stage.
// Accepts a byte-addressed load (RISC-V funct3), reads one or two aligned
// words from data memory, realigns the addressed bytes and sign- or
// zero-extends them to XLEN. XLEN must be 32 or 64.
//
// Build option MISALIGNED_EN:
//   defined   - loads that straddle a word boundary are split into two reads.
//   undefined - any load whose offset is not a multiple of its size faults
//               without touching memory.
module ld_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_fault
);

    localparam int B     = XLEN / 8;
    localparam int OFF_W = $clog2(B);
    localparam int SH_W  = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_RESP
`ifdef MISALIGNED_EN
        , S_REQ1,
        S_WAIT1
`endif
    } state_e;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [4:0] size_bytes(input logic [2:0] f3);
        return 5'd1 << f3[1:0];
    endfunction

    // Encodings that are never a load for this XLEN.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        if (f3 == 3'b111) return 1'b1;
        if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b1;
        return 1'b0;
    endfunction

    // Shift the byte pair down to the addressed byte, then push the field to
    // the top of the word and shift it back so the extension comes for free.
    function automatic logic [XLEN-1:0] align_extend(
        input logic [2*XLEN-1:0] pair,
        input logic [OFF_W-1:0]  off,
        input logic [2:0]        f3
    );
        logic [2*XLEN-1:0] shifted;
        logic [XLEN-1:0]   top;
        logic [SH_W-1:0]   sh;
        shifted = pair >> {off, 3'b000};
        sh      = SH_W'(XLEN - (8 << f3[1:0]));
        top     = shifted[XLEN-1:0] << sh;
        if (f3[2]) return top >> sh;
        return $unsigned($signed(top) >>> sh);
    endfunction

    state_e              state_q;
    logic [OFF_W-1:0]    off_q;
    logic [2:0]          f3_q;
    logic                req_ready_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_req_addr_q;
    logic                resp_valid_q;
    logic [XLEN-1:0]     resp_data_q;
    logic                resp_fault_q;

    logic [OFF_W-1:0]    req_off;
    logic                req_illegal;
    logic [2*XLEN-1:0]   resp_pair;
    logic [XLEN-1:0]     load_result;

    assign req_off = req_addr[OFF_W-1:0];

`ifdef MISALIGNED_EN
    logic [XLEN-1:0] lo_q;
    logic            crossing;

    assign req_illegal = funct3_illegal(req_funct3);
    assign crossing    = (5'(off_q) + size_bytes(f3_q)) > 5'(B);
    // The second word supplies the upper bytes of a straddling load.
    assign resp_pair   = (state_q == S_WAIT1) ? {mem_resp_data, lo_q}
                                              : {{XLEN{1'b0}}, mem_resp_data};
`else
    assign req_illegal = funct3_illegal(req_funct3)
                       | ((5'(req_off) & (size_bytes(req_funct3) - 5'd1)) != 5'd0);
    assign resp_pair   = {{XLEN{1'b0}}, mem_resp_data};
`endif

    assign load_result = align_extend(resp_pair, off_q, f3_q);

    // Load sequencer: request latch, memory reads, registered response.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of every other register, regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            off_q           <= '0;
            f3_q            <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_fault_q    <= 1'b0;
`ifdef MISALIGNED_EN
            lo_q            <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q       <= req_off;
                        f3_q        <= req_funct3;
                        req_ready_q <= 1'b0;
                        if (req_illegal) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state_q         <= S_REQ0;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (mem_resp_valid) begin
`ifdef MISALIGNED_EN
                        lo_q <= mem_resp_data;
                        if (crossing) begin
                            state_q         <= S_REQ1;
                            mem_req_valid_q <= 1'b1;
                            mem_req_addr_q  <= mem_req_addr_q + ADDR_W'(B);
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b0;
                            resp_data_q  <= load_result;
                        end
`else
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_data_q  <= load_result;
`endif
                    end
                end
`ifdef MISALIGNED_EN
                S_REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (mem_resp_valid) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_data_q  <= load_result;
                    end
                end
`endif
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= S_IDLE;
                    req_ready_q     <= 1'b1;
                    mem_req_valid_q <= 1'b0;
                    resp_valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_fault    = resp_fault_q;

endmodule

// File: tb/tb_ld_align_unit.sv
// Bench for ld_align_unit: directed cases from the load rules plus a random
// phase, checked by a response scoreboard and a memory-address scoreboard.
module tb_ld_align_unit;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int B      = XLEN / 8;

    typedef struct {
        logic [XLEN-1:0] data;
        logic            fault;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              resp_fault;

    int errors = 0;
    int checks = 0;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [XLEN-1:0]   mem[logic [ADDR_W-1:0]];

    // Environment knobs
    bit mem_rand    = 0;
    int max_delay   = 0;
    bit spurious_en = 0;
    bit hold_resp   = 0;
    int stall_req   = 0;
    bit rr_rand     = 0;
    int rr_hold     = 0;

    ld_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_funct3     (req_funct3),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [XLEN-1:0] get_word(input logic [ADDR_W-1:0] wa);
        if (!mem.exists(wa)) mem[wa] = XLEN'({$urandom, $urandom});
        return mem[wa];
    endfunction

    // Reference: gather the addressed bytes one at a time, then extend.
    task automatic model(input logic [ADDR_W-1:0] a, input logic [2:0] f);
        int                size;
        int                off;
        logic              illegal;
        logic [63:0]       val;
        logic [ADDR_W-1:0] ba;
        logic [ADDR_W-1:0] first;
        logic [XLEN-1:0]   w;
        exp_t              e;
        size    = 1 << f[1:0];
        off     = int'(a % B);
        illegal = (f == 3'b111) || (XLEN == 32 && (f == 3'b011 || f == 3'b110));
`ifndef MISALIGNED_EN
        if ((off % size) != 0) illegal = 1'b1;
`endif
        if (illegal) begin
            e.data  = '0;
            e.fault = 1'b1;
        end else begin
            val = '0;
            for (int i = 0; i < size; i++) begin
                ba = a + ADDR_W'(i);
                w  = get_word(ba - ADDR_W'(ba % B));
                val[8*i +: 8] = 8'(w >> (8 * (ba % B)));
            end
            if (!f[2] && size < 8 && val[8*size-1]) val = val | (~64'd0 << (8 * size));
            e.data  = XLEN'(val);
            e.fault = 1'b0;
            first   = a - ADDR_W'(off);
            addr_q.push_back(first);
            if (off + size > B) addr_q.push_back(first + ADDR_W'(B));
        end
        exp_q.push_back(e);
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [2:0] f);
        logic was_ready;
        model(a, f);
        req_addr   = a;
        req_funct3 = f;
        req_valid  = 1'b1;
        for (int n = 0; ; n++) begin
            was_ready = req_ready;
            @(posedge clk);
            #1;
            if (was_ready) break;
            if (n > 500) begin
                fail_now("req_accept_timeout");
                break;
            end
        end
        req_valid  = 1'b0;
        req_addr   = ADDR_W'($urandom);
        req_funct3 = 3'($urandom);
    endtask

    task automatic wait_idle();
        for (int n = 0; ; n++) begin
            if (exp_q.size() == 0 && req_ready) break;
            if (n > 2000) begin
                fail_now("idle_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_illegal(input logic [ADDR_W-1:0] a, input logic [2:0] f, input string name);
        issue(a, f);
        check({name, "_resp_next_cycle"}, resp_valid, 1'b1);
        check({name, "_no_mem_req"}, mem_req_valid, 1'b0);
        wait_idle();
    endtask

    // Memory model: one outstanding read, optional stalls, delays and noise.
    initial begin
        logic              pending;
        int                delay;
        logic [ADDR_W-1:0] paddr;
        pending        = 1'b0;
        delay          = 0;
        paddr          = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (pending) begin
                if (!hold_resp) begin
                    if (delay == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = get_word(paddr);
                        pending        = 1'b0;
                    end else begin
                        delay--;
                    end
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = XLEN'({$urandom, $urandom});
            end
            if (mem_req_valid && stall_req > 0) begin
                mem_req_ready = 1'b0;
                stall_req--;
            end else begin
                mem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (rst_n && mem_req_valid && mem_req_ready) begin
                pending = 1'b1;
                paddr   = mem_req_addr;
                delay   = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
                if (addr_q.size() == 0) begin
                    fail_now("unexpected_mem_read");
                end else begin
                    check("mem_req_addr", mem_req_addr, addr_q.pop_front());
                end
            end
        end
    end

    // Response consumer
    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_hold > 0 && resp_valid) begin
                resp_ready = 1'b0;
                rr_hold--;
            end else begin
                resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop plus hold-stable rules, sampled on negedge.
    initial begin
        logic              pv_m;
        logic              pv_r;
        logic [ADDR_W-1:0] pa;
        logic [XLEN-1:0]   pd;
        logic              pf;
        exp_t              e;
        pv_m = 1'b0;
        pv_r = 1'b0;
        pa   = '0;
        pd   = '0;
        pf   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_m = 1'b0;
                pv_r = 1'b0;
            end else begin
                if (pv_m) check("mem_req_hold", {mem_req_valid, mem_req_addr}, {1'b1, pa});
                if (pv_r) check("resp_hold", {resp_valid, resp_fault, resp_data}, {1'b1, pf, pd});
                if (resp_valid) check("req_ready_while_resp", req_ready, 1'b0);
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_resp");
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", resp_data, e.data);
                        check("resp_fault", resp_fault, e.fault);
                    end
                end
                pv_m = mem_req_valid && !mem_req_ready;
                pa   = mem_req_addr;
                pv_r = resp_valid && !resp_ready;
                pd   = resp_data;
                pf   = resp_fault;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] a;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, '0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_fault", resp_fault, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LB at 0x3 with latency probe (single read at 0x0)
        mem[32'h0] = 32'habcdef12;
        issue(32'h3, 3'b000);
        check("lb_mreq_valid_c1", mem_req_valid, 1'b1);
        check("lb_mreq_addr_c1", mem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        check("lb_resp_not_c2", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lb_resp_c3", resp_valid, 1'b1);
        wait_idle();

        // LHU / LH at 0x2
        issue(32'h2, 3'b101);
        wait_idle();
        issue(32'h2, 3'b001);
        wait_idle();

        // LW at 0x1 across the word boundary
        mem[32'h0] = 32'h44332211;
        mem[32'h4] = 32'h88776655;
`ifdef MISALIGNED_EN
        issue(32'h1, 3'b010);
        wait_idle();
`else
        issue_illegal(32'h1, 3'b010, "lw_misaligned");
`endif

        // Always-illegal encodings on this XLEN
        issue_illegal(32'h0, 3'b111, "f3_111");
        issue_illegal(32'h4, 3'b011, "f3_011");
        issue_illegal(32'h8, 3'b110, "f3_110");

        // Memory request back-pressure
        stall_req = 2;
        issue(32'h8, 3'b010);
        wait_idle();

        // Response back-pressure, with the next request already waiting
        rr_hold = 3;
        issue(32'hc, 3'b100);
        issue(32'h10, 3'b010);
        wait_idle();

        // Reset while waiting on the memory
        hold_resp = 1;
        issue(32'h10, 3'b010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_mem_req_valid", mem_req_valid, 1'b0);
        check("mid_rst_mem_req_addr", mem_req_addr, '0);
        check("mid_rst_resp_valid", resp_valid, 1'b0);
        check("mid_rst_resp_data", resp_data, '0);
        check("mid_rst_resp_fault", resp_fault, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        hold_resp = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("late_mem_resp_ignored", resp_valid, 1'b0);
        mem[32'h0] = 32'h13572468;
        issue(32'h0, 3'b010);
        wait_idle();

        // Random phase
        mem_rand    = 1;
        max_delay   = 3;
        spurious_en = 1;
        rr_rand     = 1;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) a = 32'hffff_fff8 + ADDR_W'($urandom_range(0, 7));
            else a = ADDR_W'($urandom_range(0, 31));
            issue(a, 3'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle();
        check("mem_reads_outstanding", addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
